// File: rtl/nonrestoring_div_seq_if.sv
// Bus bundle between the non-restoring divider, its requester and the input checker.
// The abort signal exists only when DIV_ABORT_EN is defined.
interface nonrestoring_div_seq_if #(
  parameter int N = 10,
  parameter int M = 5
);
  logic         start;
  logic [N-1:0] Dividend;
  logic [M-1:0] Divisor;
  logic [N-1:0] chk_dividend;
  logic [M-1:0] chk_divisor;
  logic         check_req;
  logic         validated;
  logic         OV;
  logic         DivByZero;
  logic [M-1:0] Quotient;
  logic [M-1:0] Remainder;
  logic         busy;
  logic         done;
  logic         ovf_err;
  logic         dbz_err;
`ifdef DIV_ABORT_EN
  logic         abort;
`endif

  modport master (
`ifdef DIV_ABORT_EN
    output abort,
`endif
    output start, Dividend, Divisor, validated, OV, DivByZero,
    input  chk_dividend, chk_divisor, check_req,
    input  Quotient, Remainder, busy, done, ovf_err, dbz_err
  );

  modport slave (
`ifdef DIV_ABORT_EN
    input  abort,
`endif
    input  start, Dividend, Divisor, validated, OV, DivByZero,
    output chk_dividend, chk_divisor, check_req,
    output Quotient, Remainder, busy, done, ovf_err, dbz_err
  );
endinterface

// File: rtl/nonrestoring_div_seq.sv
// Sequential non-restoring N/M unsigned divider fed by an external operand checker.
// Optional abort input enabled by defining DIV_ABORT_EN.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | waiting for start; previous result held
// S_CHECK   | operands presented to checker; verdict sampled at edge
// S_ITER    | M shift/add-subtract iterations
// S_CORRECT | final remainder fix-up and result load
// S_DONE    | one-cycle done pulse
module nonrestoring_div_seq #(
  parameter int N = 10,
  parameter int M = 5
) (
  input logic                clk,
  input logic                rst,
  nonrestoring_div_seq_if.slave bus
);
  localparam int CW = $clog2(M + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_ITER, S_CORRECT, S_DONE
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic [N-1:0] r_dividend;
  logic [M-1:0] r_divisor;
  logic [M:0]   r_rem;
  logic [M-1:0] r_q;
  logic [CW-1:0] r_cnt;
  logic [M-1:0] r_quot;
  logic [M-1:0] r_remd;
  logic         r_ovf;
  logic         r_dbz;
  logic         w_abort;
  logic [M:0]   w_rem_sh;
  logic [M:0]   w_rem_step;
  logic [M-1:0] w_q_step;
  logic [M-1:0] w_rem_fix;

`ifdef DIV_ABORT_EN
  assign w_abort = bus.abort;
`else
  assign w_abort = 1'b0;
`endif

  // Shift {R,Q} left, then add or subtract D depending on the pre-shift sign.
  assign w_rem_sh   = {r_rem[M-1:0], r_q[M-1]};
  assign w_rem_step = r_rem[M] ? (w_rem_sh + {1'b0, r_divisor})
                               : (w_rem_sh - {1'b0, r_divisor});
  assign w_q_step   = {r_q[M-2:0], ~w_rem_step[M]};
  // Corrected remainder is always in [0, D), so the low M bits suffice.
  assign w_rem_fix  = r_rem[M] ? (r_rem[M-1:0] + r_divisor) : r_rem[M-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (bus.start) w_next = S_CHECK;
      S_CHECK: begin
        if (w_abort || bus.DivByZero || bus.OV) w_next = S_DONE;
        else if (bus.validated)                 w_next = S_ITER;
        else                                    w_next = S_DONE;
      end
      S_ITER: begin
        if (w_abort)                 w_next = S_DONE;
        else if (r_cnt == CW'(1))    w_next = S_CORRECT;
      end
      S_CORRECT: w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dividend <= '0;
      r_divisor  <= '0;
      r_rem      <= '0;
      r_q        <= '0;
      r_cnt      <= '0;
      r_quot     <= '0;
      r_remd     <= '0;
      r_ovf      <= 1'b0;
      r_dbz      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_dividend <= bus.Dividend;
            r_divisor  <= bus.Divisor;
            r_quot     <= '0;
            r_remd     <= '0;
            r_ovf      <= 1'b0;
            r_dbz      <= 1'b0;
          end
        end
        S_CHECK: begin
          if (!w_abort) begin
            if (bus.DivByZero) r_dbz <= 1'b1;
            else if (bus.OV)   r_ovf <= 1'b1;
            else if (bus.validated) begin
              r_rem <= {1'b0, r_dividend[N-1:M]};
              r_q   <= r_dividend[M-1:0];
              r_cnt <= CW'(M);
            end
          end
        end
        S_ITER: begin
          if (!w_abort) begin
            r_rem <= w_rem_step;
            r_q   <= w_q_step;
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_CORRECT: begin
          if (!w_abort) begin
            r_quot <= r_q;
            r_remd <= w_rem_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.chk_dividend = r_dividend;
  assign bus.chk_divisor  = r_divisor;
  assign bus.check_req    = (r_state == S_CHECK);
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.done         = (r_state == S_DONE);
  assign bus.Quotient     = r_quot;
  assign bus.Remainder    = r_remd;
  assign bus.ovf_err      = r_ovf;
  assign bus.dbz_err      = r_dbz;
endmodule
